fault_campaign_ctrl: RTL and testbench

FAULT_CAMPAIGN_CTRL -- requirements
Module: fault_campaign_ctrl

---
 rtl/fault_campaign_ctrl.sv | 106 ++++++++++
 tb/tb_fault_campaign_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_campaign_ctrl.sv
// Bit-by-bit fault injection sequencer: captures a golden ciphertext, then
// faults each bit in turn and hands each faulty ciphertext off over valid/ready.
module fault_campaign_ctrl #(
  parameter int AES_LAT   = 21,
  parameter int FIRST_BIT = 0,
  parameter int LAST_BIT  = 127
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  output logic         fault_en,
  output logic [6:0]   fault_bit,
  input  logic         cap_ready,
  output logic         cap_valid,
  output logic [6:0]   cap_bit,
  output logic [127:0] cap_faulty,
  output logic [127:0] cap_diff,
  output logic [127:0] golden,
  output logic [7:0]   hits,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GOLD  = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;
  localparam logic [1:0] CAP   = 2'd3;

  localparam logic [7:0] CNT_END  = 8'(AES_LAT - 1);
  localparam logic [6:0] FIRST_IX = 7'(FIRST_BIT);
  localparam logic [6:0] LAST_IX  = 7'(LAST_BIT);

  logic [1:0]   state;
  logic [7:0]   cnt;
  logic [127:0] diff;
  logic         cnt_end;
  logic         last;

  assign diff    = ciphertext ^ golden;
  assign cnt_end = (cnt == CNT_END);
  assign last    = (fault_bit == LAST_IX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      fault_en   <= 1'b0;
      fault_bit  <= '0;
      cap_valid  <= 1'b0;
      cap_bit    <= '0;
      cap_faulty <= '0;
      cap_diff   <= '0;
      golden     <= '0;
      hits       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= GOLD;
          cnt      <= '0;
          busy     <= 1'b1;
          done     <= 1'b0;
          hits     <= '0;
          fault_en <= 1'b0;
        end
        GOLD: if (cnt_end) begin
          golden    <= ciphertext;
          fault_bit <= FIRST_IX;
          fault_en  <= 1'b1;
          cnt       <= '0;
          state     <= FAULT;
        end else begin
          cnt <= cnt + 8'd1;
        end
        FAULT: if (cnt_end) begin
          cap_faulty <= ciphertext;
          cap_diff   <= diff;
          cap_bit    <= fault_bit;
          cap_valid  <= 1'b1;
          // hits tracks captures that actually perturbed the output
          if ((|diff) && (hits != 8'hFF)) hits <= hits + 8'd1;
          state      <= CAP;
        end else begin
          cnt <= cnt + 8'd1;
        end
        CAP: if (cap_ready) begin
          cap_valid <= 1'b0;
          if (last) begin
            fault_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            fault_bit <= fault_bit + 7'd1;
            cnt       <= '0;
            state     <= FAULT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Self-checking bench: full 128-bit campaigns with stub AES cores, random
// backpressure, mid-campaign reset and a single-bit campaign instance.
module tb_fault_campaign_ctrl;

  localparam int L   = 3;
  localparam int L1  = 4;
  localparam int FB  = 0;
  localparam int LB  = 127;
  localparam int OB  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, cap_ready;
  logic [127:0] ciphertext;
  logic         fault_en, cap_valid, busy, done;
  logic [6:0]   fault_bit, cap_bit;
  logic [127:0] cap_faulty, cap_diff, golden;
  logic [7:0]   hits;

  logic         one_start, one_ready;
  logic [127:0] one_ct;
  logic         one_fault_en, one_valid, one_busy, one_done;
  logic [6:0]   one_fault_bit, one_cap_bit;
  logic [127:0] one_faulty, one_diff, one_golden;
  logic [7:0]   one_hits;

  fault_campaign_ctrl #(.AES_LAT(L), .FIRST_BIT(FB), .LAST_BIT(LB)) u_dut (
    .clk(clk), .rst(rst), .start(start), .ciphertext(ciphertext),
    .fault_en(fault_en), .fault_bit(fault_bit), .cap_ready(cap_ready),
    .cap_valid(cap_valid), .cap_bit(cap_bit), .cap_faulty(cap_faulty),
    .cap_diff(cap_diff), .golden(golden), .hits(hits), .busy(busy), .done(done)
  );

  fault_campaign_ctrl #(.AES_LAT(L1), .FIRST_BIT(OB), .LAST_BIT(OB)) u_one (
    .clk(clk), .rst(rst), .start(one_start), .ciphertext(one_ct),
    .fault_en(one_fault_en), .fault_bit(one_fault_bit), .cap_ready(one_ready),
    .cap_valid(one_valid), .cap_bit(one_cap_bit), .cap_faulty(one_faulty),
    .cap_diff(one_diff), .golden(one_golden), .hits(one_hits), .busy(one_busy),
    .done(one_done)
  );

  // stub AES cores: mode 0 one-hot, 1 constant, 2 random table
  int           mode;
  logic [127:0] rtab [128];
  logic [127:0] rgold;

  always_comb begin
    ciphertext = '0;
    case (mode)
      0:       ciphertext = fault_en ? (128'd1 << fault_bit) : '0;
      1:       ciphertext = 128'h55;
      default: ciphertext = fault_en ? rtab[fault_bit] : rgold;
    endcase
  end

  assign one_ct = one_fault_en ? (128'd1 << one_fault_bit) : '0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] model_ct(input int md, input int k);
    case (md)
      0:       return 128'd1 << k;
      1:       return 128'h55;
      default: return rtab[k];
    endcase
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_fault_en"},  128'(fault_en),  '0);
    check({tag, "_fault_bit"}, 128'(fault_bit), '0);
    check({tag, "_cap_valid"}, 128'(cap_valid), '0);
    check({tag, "_cap_bit"},   128'(cap_bit),   '0);
    check({tag, "_cap_faulty"}, cap_faulty,     '0);
    check({tag, "_cap_diff"},  cap_diff,        '0);
    check({tag, "_golden"},    golden,          '0);
    check({tag, "_hits"},      128'(hits),      '0);
    check({tag, "_busy"},      128'(busy),      '0);
    check({tag, "_done"},      128'(done),      '0);
  endtask

  // One full campaign on u_dut. The model expects capture k to appear a fixed
  // number of cycles after start or after the previous transfer, with fields
  // derived from the stub's rule, and holds it until a ready is driven.
  task automatic run_campaign(input int md, input int pct, input int stall,
                              input logic use_tbl, input logic [127:0] eg, input int eh);
    logic [127:0] g, ct;
    int k, due, n, mhits, budget;
    logic rdy, fin;
    mode = md;
    if (md == 2) begin
      rgold = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 128; i++)
        rtab[i] = ($urandom_range(3) == 0) ? rgold : {$urandom, $urandom, $urandom, $urandom};
    end
    g = (md == 1) ? 128'h55 : ((md == 2) ? rgold : '0);
    @(negedge clk);
    start = 1'b1;
    cap_ready = 1'($urandom_range(1));
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check("start_busy", 128'(busy), 128'(1));
    check("start_done", 128'(done), '0);
    check("start_hits", 128'(hits), '0);
    check("start_fen",  128'(fault_en), '0);
    k = FB; due = 2 * L + 1; mhits = 0; fin = 1'b0; budget = 20000;
    while (!fin && n < budget) begin
      if (n < due) begin
        check("idle_valid", 128'(cap_valid), '0);
        check("run_busy",   128'(busy), 128'(1));
      end else begin
        ct = model_ct(md, k);
        if (n == due && ct != g && mhits < 255) mhits++;
        check("cap_valid",  128'(cap_valid), 128'(1));
        check("cap_bit",    128'(cap_bit),   128'(k));
        check("fault_bit",  128'(fault_bit), 128'(k));
        check("cap_faulty", cap_faulty, ct);
        check("cap_diff",   cap_diff,   ct ^ g);
        check("hits_run",   128'(hits), 128'(mhits));
        check("golden_run", golden, g);
      end
      if (n >= due && k == FB && n < due + stall) rdy = 1'b0;
      else rdy = ($urandom_range(99) < pct);
      cap_ready = rdy;
      start = ($urandom_range(7) == 0);
      if (n >= due && rdy) begin
        if (k == LB) begin
          fin = 1'b1;
          start = 1'b1;  // must not restart on the final transfer
        end else begin
          k++;
          due = n + L + 1;
        end
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    cap_ready = 1'b0;
    check("finished", 128'(fin), 128'(1));
    check("end_done",  128'(done), 128'(1));
    check("end_busy",  128'(busy), '0);
    check("end_valid", 128'(cap_valid), '0);
    check("end_fen",   128'(fault_en), '0);
    check("end_hits",  128'(hits), use_tbl ? 128'(eh) : 128'(mhits));
    check("end_golden", golden, use_tbl ? eg : g);
    if (pct == 100 && stall == 0)
      check("done_cycle", 128'(n), 128'(2 * L + 1 + (LB - FB) * (L + 1) + 1));
    @(negedge clk);
    check("done_held", 128'(done), 128'(1));
    check("idle_busy", 128'(busy), '0);
  endtask

  typedef struct {
    int           md;
    int           pct;
    int           stall;
    logic         use_tbl;
    logic [127:0] eg;
    int           eh;
  } camp_t;

  initial begin
    camp_t tbl [5];
    int cnt, n;
    logic seen;
    tbl[0] = '{md: 0, pct: 100, stall: 0,  use_tbl: 1'b1, eg: 128'h0,  eh: 128};
    tbl[1] = '{md: 0, pct: 100, stall: 10, use_tbl: 1'b1, eg: 128'h0,  eh: 128};
    tbl[2] = '{md: 1, pct: 100, stall: 0,  use_tbl: 1'b1, eg: 128'h55, eh: 0};
    tbl[3] = '{md: 2, pct: 60,  stall: 0,  use_tbl: 1'b0, eg: 128'h0,  eh: 0};
    tbl[4] = '{md: 2, pct: 25,  stall: 0,  use_tbl: 1'b0, eg: 128'h0,  eh: 0};

    mode = 0; rst = 1'b1; start = 1'b1; cap_ready = 1'b1;
    one_start = 1'b1; one_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rst");
    check("one_rst_busy", 128'(one_busy), '0);
    check("one_rst_done", 128'(one_done), '0);
    rst = 1'b0; start = 1'b0; one_start = 1'b0;
    @(negedge clk);
    check("idle_hold", 128'(busy), '0);

    for (int i = 0; i < 3; i++)
      run_campaign(tbl[i].md, tbl[i].pct, tbl[i].stall, tbl[i].use_tbl, tbl[i].eg, tbl[i].eh);

    // reset in the middle of a campaign, while bit 40 is being faulted
    mode = 0;
    @(negedge clk);
    start = 1'b1; cap_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (fault_bit == 7'd40 && !cap_valid && fault_en) seen = 1'b1;
      else @(negedge clk);
    end
    check("reach_bit40", 128'(seen), 128'(1));
    rst = 1'b1; start = 1'b1; cap_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; cap_ready = 1'b0;
    check_reset("midrst");
    @(negedge clk);
    check("midrst_idle", 128'(busy), '0);

    for (int i = 3; i < 5; i++)
      run_campaign(tbl[i].md, tbl[i].pct, tbl[i].stall, tbl[i].use_tbl, tbl[i].eg, tbl[i].eh);

    // single-bit campaign, twice, with a start pulse during busy
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      one_start = 1'b1;
      @(negedge clk);
      one_start = 1'b0;
      n = 1; cnt = 0;
      check("one_start_busy", 128'(one_busy), 128'(1));
      check("one_start_done", 128'(one_done), '0);
      check("one_start_hits", 128'(one_hits), '0);
      while (!one_done && n < 200) begin
        if (n == 3) one_start = 1'b1;
        else one_start = 1'b0;
        if (one_valid) begin
          cnt++;
          check("one_cap_bit",  128'(one_cap_bit), 128'(OB));
          check("one_cap_diff", one_diff, 128'd1 << OB);
        end
        @(negedge clk);
        n++;
      end
      one_start = 1'b0;
      check("one_caps",       128'(cnt), 128'(1));
      check("one_done",       128'(one_done), 128'(1));
      check("one_busy_end",   128'(one_busy), '0);
      check("one_hits",       128'(one_hits), 128'(1));
      check("one_done_cycle", 128'(n), 128'(2 * L1 + 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
